// File: rtl/daq_mem_pkg.sv
// Shared definitions for the DAQ memory-port arbiter.
// Holds the default widths and watchdog limits, plus the arbiter state enum.
package daq_mem_pkg;

    localparam int ADDR_W_DEF        = 26;
    localparam int DATA_W_DEF        = 32;
    localparam int ISSUE_TIMEOUT_DEF = 16;
    localparam int DONE_TIMEOUT_DEF  = 4096;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        ACK
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant.
// Ports:
//   clk, reset   - clock, async active-high reset
//   req[1:0]     - request vector (bit i = requester i)
//   update       - load the pointer with the current grant
//   grant_idx    - index of the winning requester
//   grant_valid  - at least one request present
// The pointer remembers the last granted index; on a tie the other index wins.
// It resets to 1 so requester 0 takes the first tie.
module rr_arb2
    import daq_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic       grant_idx,
    output logic       grant_valid
);

    logic rr_last_q;
    logic rr_last_d;

    always_comb begin
        grant_valid = |req;
        if (req == 2'b11) begin
            grant_idx = ~rr_last_q;
        end else begin
            grant_idx = req[1];
        end
        rr_last_d = rr_last_q;
        if (update && grant_valid) begin
            rr_last_d = grant_idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_last_q <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single processor-side memory port between the control unit
// (requester 0) and the ADC capture path (requester 1).
// One transaction at a time is latched, strobed to memory, tracked through
// memory_busy, and completed with a one-cycle ack and read data.
// Ports:
//   clk, reset                  - clock, async active-high reset
//   cN_req/we/addr/wdata        - requester N transaction (level req until ack)
//   cN_ack, cN_rdata            - one-cycle completion and read data
//   memory_read_req/write_req   - one-cycle strobes to the memory port
//   memory_addr/data_write      - latched transaction fields
//   memory_data_read, busy      - memory port response
//   owner                       - requester of the current or last grant
//   timeout_err, clear_err      - sticky watchdog flag and its clear
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | wait for a request while memory is not busy; grant + latch
// ISSUE     | read or write strobe high for exactly this cycle
// WAIT_BUSY | wait for memory_busy to rise (ISSUE_TIMEOUT watchdog)
// WAIT_DONE | wait for memory_busy to fall (DONE_TIMEOUT watchdog)
// ACK       | owner's ack high, rdata valid
module mem_port_arbiter
    import daq_mem_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int ISSUE_TIMEOUT = ISSUE_TIMEOUT_DEF,
    parameter int DONE_TIMEOUT  = DONE_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c0_req,
    input  logic              c0_we,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [DATA_W-1:0] c0_wdata,
    output logic              c0_ack,
    output logic [DATA_W-1:0] c0_rdata,
    input  logic              c1_req,
    input  logic              c1_we,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic              c1_ack,
    output logic [DATA_W-1:0] c1_rdata,
    output logic              memory_read_req,
    output logic              memory_write_req,
    output logic [ADDR_W-1:0] memory_addr,
    output logic [DATA_W-1:0] memory_data_write,
    input  logic [DATA_W-1:0] memory_data_read,
    input  logic              memory_busy,
    output logic              owner,
    output logic              timeout_err,
    input  logic              clear_err
);

    localparam int CNT_W = $clog2(DONE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;
    localparam logic [CNT_W-1:0] ISSUE_LIM = CNT_W'(ISSUE_TIMEOUT);
    localparam logic [CNT_W-1:0] DONE_LIM  = CNT_W'(DONE_TIMEOUT);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              we_q, we_d;
    logic              owner_q, owner_d;
    logic              rd_req_q, rd_req_d;
    logic              wr_req_q, wr_req_d;
    logic [1:0]        ack_q, ack_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              timeout_err_q, timeout_err_d;

    logic              grant_idx, grant_valid, grant_take;
    logic              finish, set_err;
    logic [DATA_W-1:0] finish_data;

    rr_arb2 u_rr (
        .clk         (clk),
        .reset       (reset),
        .req         ({c1_req, c0_req}),
        .update      (grant_take),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_req_d    = 1'b0;
        wr_req_d    = 1'b0;
        ack_d       = 2'b00;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        grant_take  = 1'b0;
        finish      = 1'b0;
        set_err     = 1'b0;
        finish_data = '0;
        // Saturating increment: the watchdog never wraps back to zero.
        cnt_inc     = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                if (!memory_busy && grant_valid) begin
                    grant_take = 1'b1;
                    owner_d    = grant_idx;
                    we_d       = grant_idx ? c1_we    : c0_we;
                    addr_d     = grant_idx ? c1_addr  : c0_addr;
                    wdata_d    = grant_idx ? c1_wdata : c0_wdata;
                    // Strobes are registered so they are high during ISSUE.
                    wr_req_d   = we_d;
                    rd_req_d   = !we_d;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (memory_busy) begin
                    cnt_d   = '0;
                    state_d = WAIT_DONE;
                end else if (cnt_inc >= ISSUE_LIM) begin
                    finish  = 1'b1;
                    set_err = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WAIT_DONE: begin
                if (!memory_busy) begin
                    finish      = 1'b1;
                    finish_data = we_q ? '0 : memory_data_read;
                end else if (cnt_inc >= DONE_LIM) begin
                    finish  = 1'b1;
                    set_err = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Completion (normal or watchdog) loads only the owner's rdata.
        if (finish) begin
            state_d = ACK;
            ack_d   = owner_q ? 2'b10 : 2'b01;
            if (owner_q) begin
                rdata1_d = finish_data;
            end else begin
                rdata0_d = finish_data;
            end
        end

        // A watchdog hit wins over a simultaneous clear request.
        timeout_err_d = set_err ? 1'b1 : (clear_err ? 1'b0 : timeout_err_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            we_q          <= 1'b0;
            owner_q       <= 1'b0;
            rd_req_q      <= 1'b0;
            wr_req_q      <= 1'b0;
            ack_q         <= 2'b00;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            we_q          <= we_d;
            owner_q       <= owner_d;
            rd_req_q      <= rd_req_d;
            wr_req_q      <= wr_req_d;
            ack_q         <= ack_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rdata0_q      <= rdata0_d;
            rdata1_q      <= rdata1_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign c0_ack            = ack_q[0];
    assign c1_ack            = ack_q[1];
    assign c0_rdata          = rdata0_q;
    assign c1_rdata          = rdata1_q;
    assign memory_read_req   = rd_req_q;
    assign memory_write_req  = wr_req_q;
    assign memory_addr       = addr_q;
    assign memory_data_write = wdata_q;
    assign owner             = owner_q;
    assign timeout_err       = timeout_err_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single processor-side memory port (read/write req, 26-bit word address, 32-bit data, busy) between two requesters.
- Requester 0 is the control unit; requester 1 is the ADC capture path.
- Sits between those clients and the hardware abstraction layer: latches one transaction, issues it, tracks memory_busy to completion, returns the read data and an ack.
- Round-robin fairness and a busy-handshake watchdog.

Parameters:
- ADDR_W, 26, memory word address width
- DATA_W, 32, memory data width
- ISSUE_TIMEOUT, 16, max cycles in WAIT_BUSY for memory_busy to rise after a request pulse
- DONE_TIMEOUT, 4096, max cycles in WAIT_DONE for memory_busy to fall

Ports:
- clk  in  1  design clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- c0_req  in  1  requester 0 transaction request, level, held until c0_ack
- c0_we  in  1  1=write, 0=read; valid with c0_req
- c0_addr  in  ADDR_W  word address
- c0_wdata  in  DATA_W  write data
- c0_ack  out  1  one-cycle completion pulse
- c0_rdata  out  DATA_W  read data; valid while c0_ack high
- c1_req, c1_we, c1_addr, c1_wdata, c1_ack, c1_rdata  same as c0, for requester 1
- memory_read_req  out  1  one-cycle read strobe to memory port
- memory_write_req  out  1  one-cycle write strobe to memory port
- memory_addr  out  ADDR_W  latched transaction address
- memory_data_write  out  DATA_W  latched write data
- memory_data_read  in  DATA_W  read data; valid on the first cycle memory_busy is low after the op
- memory_busy  in  1  high while the memory port is executing an op
- owner  out  1  requester index of the current or last grant
- timeout_err  out  1  sticky watchdog flag
- clear_err  in  1  synchronous clear of timeout_err

Behaviour:
- Reset values:
  - state=IDLE
  - all strobes, acks, timeout_err, memory_addr, memory_data_write, c*_rdata = 0
  - owner=0; rr_last=1, so requester 0 wins the first tie
- Reset mid-operation abandons the in-flight op. No ack is issued.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, ACK.
- IDLE:
  - If memory_busy=0 and any req=1, grant and latch we/addr/wdata into memory_addr/memory_data_write, set owner, go ISSUE.
  - If memory_busy=1, stay in IDLE.
- Arbitration:
  - Single requester: grant it.
  - Both requesting: grant the index != rr_last.
  - rr_last is updated to the granted index on entry to ISSUE.
- ISSUE (exactly 1 cycle):
  - memory_write_req=we, memory_read_req=!we; both are registered outputs, never both high.
  - Clear the watchdog counter. Go WAIT_BUSY.
- WAIT_BUSY:
  - memory_busy=1 -> WAIT_DONE, counter cleared.
  - Counter reaches ISSUE_TIMEOUT -> set timeout_err, rdata=0, go ACK.
- WAIT_DONE:
  - memory_busy=0 -> capture memory_data_read into owner's rdata (reads only; writes leave rdata=0), go ACK.
  - Counter reaches DONE_TIMEOUT -> set timeout_err, rdata=0, go ACK.
- ACK (1 cycle): owner's c*_ack=1, the other ack=0. Next state IDLE.
- Requester contract:
  - Deassert req, or present a new transaction, in the cycle after ack.
  - A req still high in IDLE is a new transaction.
  - Inputs changing while not in IDLE are ignored because fields are latched.
- Minimum latency: req sampled at cycle N; mem strobe at N+1; busy high at N+2; busy low at M; ack at M+1.
- Throughput: a back-to-back competing requester is granted next. Strict alternation when both are continuously requesting.
- timeout_err:
  - Set has priority over clear_err in the same cycle.
  - Cleared only by clear_err or reset.
- Watchdog counters are ceil(log2(DONE_TIMEOUT+1)) wide and saturate; no wrap.

Decomposition:
- Package daq_mem_pkg holds:
  - ADDR_W/DATA_W defaults
  - state enum (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, ACK)
  - timeout defaults
- One natural sub-module, rr_arb2: a 2-way round-robin grant with rr_last pointer, taking req[1:0] and an update strobe, producing grant index and valid.

Test Plan:
- Single read: c0_req, we=0, addr=0x0001234; memory model busy 3 cycles returning 0xCAFEF00D -> one memory_read_req pulse with memory_addr=0x0001234; c0_ack one cycle with c0_rdata=0xCAFEF00D; c1_ack never.
- Contention: c0 and c1 both held high, 4 transactions each -> grants alternate 0,1,0,1,...; each ack one cycle; no strobe overlap; never two strobes without busy completing between.
- Write: c1 we=1, addr=0x3FFFFFF, wdata=0xA5A5A5A5 -> memory_write_req pulse with matching addr/data; c1_rdata=0 at ack.
- Busy held high in IDLE: memory_busy=1 for 10 cycles while c0_req=1 -> no strobe until busy=0; then normal issue.
- Watchdog: model never raises busy -> ack exactly ISSUE_TIMEOUT cycles after WAIT_BUSY entry, timeout_err=1 and stays set; clear_err pulse -> 0; set and clear in the same cycle -> stays 1.
- Reset mid-op: assert reset in WAIT_DONE -> all outputs 0 within the same cycle (async); after release, c0 wins the first tie.
